// File: rtl/raw_pulse_conditioner_pkg.sv
// Shared state encodings, 40 MHz timing defaults and a saturating counter helper
// for the interrupter pulse conditioner.
package raw_pulse_conditioner_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ON    = 2'd1,
      S_OFF   = 2'd2,
      S_FAULT = 2'd3
   } state_e;

   localparam int unsigned C_FILT_CYC       = 4;
   localparam int unsigned C_MAX_ON_CYC     = 8000;
   localparam int unsigned C_MIN_OFF_CYC    = 400;
   localparam int unsigned C_FAULT_HOLD_CYC = 4000000;
   localparam int unsigned C_CNT_W          = 24;
   localparam logic [15:0] C_TRUNC_MAX      = 16'hFFFF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic [15:0] max_v);
      return (v >= max_v) ? max_v : v + 16'd1;
   endfunction

endpackage

// File: rtl/raw_pulse_conditioner_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output level only
// follows the input after P_FILT_CYC consecutive differing samples.
module raw_pulse_conditioner_glitch_filter #(
   parameter int unsigned P_FILT_CYC = 4
) (
   input  logic i_clk,
   input  logic i_res_n,
   input  logic i_async,
   output logic o_level
);

   localparam int unsigned           L_W    = $clog2(P_FILT_CYC + 1);
   localparam logic [L_W-1:0]        L_LAST = L_W'(P_FILT_CYC - 1);

   logic           sync1_q;
   logic           sync2_q;
   logic           level_q;
   logic           level_d;
   logic [L_W-1:0] cnt_q;
   logic [L_W-1:0] cnt_d;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_async;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Any sample matching the current level restarts the qualification.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == L_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + L_W'(1);
         end
      end
   end

   assign o_level = level_q;

endmodule

// File: rtl/raw_pulse_conditioner.sv
// Interrupter pulse conditioner: filtered input, max on-time truncation, min
// off-time, over-current lockout and a saturating truncation counter.
module raw_pulse_conditioner
   import raw_pulse_conditioner_pkg::*;
#(
   parameter int unsigned P_FILT_CYC       = C_FILT_CYC,
   parameter int unsigned P_MAX_ON_CYC     = C_MAX_ON_CYC,
   parameter int unsigned P_MIN_OFF_CYC    = C_MIN_OFF_CYC,
   parameter int unsigned P_FAULT_HOLD_CYC = C_FAULT_HOLD_CYC,
   parameter int unsigned P_CNT_W          = C_CNT_W,
   parameter logic [15:0] P_TRUNC_MAX      = C_TRUNC_MAX
) (
   input  logic        i_clk,
   input  logic        i_res_n,
   input  logic        i_en,
   input  logic        i_raw_pls,
   input  logic        i_over_current,
   input  logic        i_fault_clr,
   output logic        o_pls,
   output logic        o_fault,
   output logic [15:0] o_trunc_cnt,
   output logic [1:0]  o_state
);

   localparam logic [P_CNT_W-1:0] L_ON_LAST    = P_CNT_W'(P_MAX_ON_CYC - 1);
   localparam logic [P_CNT_W-1:0] L_OFF_LAST   = P_CNT_W'(P_MIN_OFF_CYC - 1);
   localparam logic [P_CNT_W-1:0] L_FAULT_LAST = P_CNT_W'(P_FAULT_HOLD_CYC - 1);

   logic               filt_lvl;
   state_e             state_q, state_d;
   logic [P_CNT_W-1:0] timer_q, timer_d;
   logic [15:0]        trunc_q, trunc_d;
   logic               pls_q, pls_d;
   logic               fault_q, fault_d;
   logic               trunc_inc;

   raw_pulse_conditioner_glitch_filter #(
      .P_FILT_CYC (P_FILT_CYC)
   ) u_filt (
      .i_clk   (i_clk),
      .i_res_n (i_res_n),
      .i_async (i_raw_pls),
      .o_level (filt_lvl)
   );

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         trunc_q <= '0;
         pls_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         trunc_q <= trunc_d;
         pls_q   <= pls_d;
         fault_q <= fault_d;
      end
   end

   // The timer saturates so a long wait in S_OFF cannot wrap below the min-off threshold.
   always_comb begin
      state_d   = state_q;
      timer_d   = (timer_q == '1) ? timer_q : timer_q + P_CNT_W'(1);
      trunc_inc = 1'b0;
      if (i_over_current) begin
         state_d   = S_FAULT;
         timer_d   = '0;
         trunc_inc = (state_q == S_ON) && filt_lvl && (timer_q == L_ON_LAST);
      end else if (state_q == S_FAULT) begin
         if ((timer_q >= L_FAULT_LAST) || i_fault_clr) begin
            state_d = S_OFF;
            timer_d = '0;
         end
      end else if (!i_en) begin
         state_d = S_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (filt_lvl) begin
                  state_d = S_ON;
                  timer_d = '0;
               end
            end
            S_ON: begin
               if (!filt_lvl) begin
                  state_d = S_OFF;
                  timer_d = '0;
               end else if (timer_q == L_ON_LAST) begin
                  state_d   = S_OFF;
                  timer_d   = '0;
                  trunc_inc = 1'b1;
               end
            end
            S_OFF: begin
               if ((timer_q >= L_OFF_LAST) && !filt_lvl) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pls_d   = (state_d == S_ON);
      fault_d = (state_d == S_FAULT);
      trunc_d = trunc_inc ? sat_inc16(trunc_q, P_TRUNC_MAX) : trunc_q;
   end

   assign o_pls       = pls_q;
   assign o_fault     = fault_q;
   assign o_trunc_cnt = trunc_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_raw_pulse_conditioner.sv
// Scoreboard bench: each driven pulse queues its expected latency and width,
// the negedge monitor measures every o_pls pulse and compares against the queue.
module tb_raw_pulse_conditioner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        raw;
   logic        oc;
   logic        fclr;
   logic        o_pls;
   logic        o_fault;
   logic [15:0] o_trunc_cnt;
   logic [1:0]  o_state;

   typedef struct {
      int lat;
      int width;
   } exp_t;

   exp_t sb[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   rise_cyc = 0;
   int   n_exp    = 0;
   int   n_seen   = 0;

   raw_pulse_conditioner #(
      .P_FILT_CYC       (4),
      .P_MAX_ON_CYC     (100),
      .P_MIN_OFF_CYC    (20),
      .P_FAULT_HOLD_CYC (50),
      .P_CNT_W          (8),
      .P_TRUNC_MAX      (16'd3)
   ) dut (
      .i_clk          (clk),
      .i_res_n        (rst_n),
      .i_en           (en),
      .i_raw_pls      (raw),
      .i_over_current (oc),
      .i_fault_clr    (fclr),
      .o_pls          (o_pls),
      .o_fault        (o_fault),
      .o_trunc_cnt    (o_trunc_cnt),
      .o_state        (o_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input int lat, input int width);
      exp_t e;
      e.lat   = lat;
      e.width = width;
      sb.push_back(e);
      n_exp++;
   endtask

   task automatic raise_raw();
      raw      = 1'b1;
      rise_cyc = cyc;
   endtask

   // Pulse monitor: width is discarded when reset cuts a pulse short.
   initial begin
      int   width;
      int   lat;
      exp_t e;
      width = 0;
      lat   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            width = 0;
         end else if (o_pls) begin
            if (width == 0) lat = cyc - rise_cyc;
            width++;
         end else if (width > 0) begin
            n_seen++;
            if (sb.size() == 0) begin
               check_val("sb_unexpected_pulse", width, 0);
            end else begin
               e = sb.pop_front();
               if (e.lat >= 0) check_val("sb_latency", lat, e.lat);
               check_val("sb_width", width, e.width);
            end
            width = 0;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      raw   = 1'b0;
      oc    = 1'b0;
      fclr  = 1'b0;
      tick(3);
      check_val("rst_pls", o_pls, 0);
      check_val("rst_fault", o_fault, 0);
      check_val("rst_trunc", o_trunc_cnt, 0);
      check_val("rst_state", o_state, 0);
      rst_n = 1'b1;
      tick(3);

      // 3-clock glitch is rejected
      raise_raw();
      tick(3);
      raw = 1'b0;
      tick(15);
      check_val("glitch_pls", o_pls, 0);
      check_val("glitch_state", o_state, 0);

      // 40-clock pulse passes unchanged
      expect_pulse(7, 40);
      raise_raw();
      tick(40);
      raw = 1'b0;
      tick(40);
      check_val("p40_trunc", o_trunc_cnt, 0);
      check_val("p40_state", o_state, 0);

      // 300-clock pulse is cut at 100, S_OFF held while input high
      expect_pulse(7, 100);
      raise_raw();
      tick(300);
      check_val("p300_state_off", o_state, 2);
      check_val("p300_trunc", o_trunc_cnt, 1);
      raw = 1'b0;
      tick(40);
      check_val("p300_state_idle", o_state, 0);

      // Re-rise inside min-off is dropped
      expect_pulse(7, 40);
      raise_raw();
      tick(40);
      raw = 1'b0;
      tick(10);
      raw = 1'b1;
      tick(15);
      check_val("reris_pls", o_pls, 0);
      tick(15);
      raw = 1'b0;
      tick(40);
      check_val("reris_state", o_state, 0);

      // Over-current strobe mid-pulse, full hold time
      expect_pulse(7, 10);
      raise_raw();
      tick(16);
      oc = 1'b1;
      tick(1);
      oc = 1'b0;
      check_val("oc_pls", o_pls, 0);
      check_val("oc_fault", o_fault, 1);
      check_val("oc_state", o_state, 3);
      tick(49);
      check_val("oc_fault_held", o_fault, 1);
      tick(1);
      check_val("oc_fault_end", o_fault, 0);
      check_val("oc_state_off", o_state, 2);
      raw = 1'b0;
      tick(40);
      check_val("oc_state_idle", o_state, 0);

      // Early release; clear ignored while over-current still asserted
      expect_pulse(7, 10);
      raise_raw();
      tick(16);
      oc = 1'b1;
      tick(1);
      fclr = 1'b1;
      tick(1);
      check_val("clr_ignored", o_fault, 1);
      oc   = 1'b0;
      fclr = 1'b0;
      tick(3);
      check_val("clr_fault_before", o_fault, 1);
      fclr = 1'b1;
      tick(1);
      fclr = 1'b0;
      check_val("clr_fault_after", o_fault, 0);
      check_val("clr_state_off", o_state, 2);
      raw = 1'b0;
      tick(40);

      // Enable drop mid-pulse
      expect_pulse(7, 5);
      raise_raw();
      tick(11);
      en = 1'b0;
      tick(1);
      check_val("en_pls", o_pls, 0);
      check_val("en_state", o_state, 0);
      raw = 1'b0;
      tick(15);
      en = 1'b1;
      tick(10);

      // Over-current on the truncation clock still counts the truncation
      expect_pulse(7, 100);
      raise_raw();
      tick(106);
      oc = 1'b1;
      tick(1);
      oc = 1'b0;
      check_val("octr_state", o_state, 3);
      check_val("octr_trunc", o_trunc_cnt, 2);
      tick(50);
      check_val("octr_state_off", o_state, 2);
      raw = 1'b0;
      tick(40);

      // Truncation counter saturation
      for (int i = 0; i < 3; i++) begin
         expect_pulse(7, 100);
         raise_raw();
         tick(120);
         raw = 1'b0;
         tick(40);
      end
      check_val("sat_trunc", o_trunc_cnt, 3);

      // Async reset mid-pulse, then fresh qualification of a still-high input
      raise_raw();
      tick(10);
      check_val("ar_pls_before", o_pls, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("ar_pls_async", o_pls, 0);
      check_val("ar_trunc", o_trunc_cnt, 0);
      check_val("ar_state", o_state, 0);
      tick(2);
      rst_n = 1'b1;
      expect_pulse(-1, 30);
      tick(5);
      check_val("ar_requal_low", o_pls, 0);
      tick(3);
      check_val("ar_requal_high", o_pls, 1);
      tick(22);
      raw = 1'b0;
      tick(40);

      check_val("sb_drained", sb.size(), 0);
      check_val("pulse_count", n_seen, n_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
